led_ctrl: RTL
=============

Name: led_ctrl

Overview:
- Memory-mapped LED output peripheral on the CPU bridge. It is the next generation of the plain byte-enable LED register.
- Adds a parametrised LED count, a per-word register file with readback, global PWM brightness and a hardware blink timer.
- The CPU writes 32-bit words with byte enables. The block drives active-low board LEDs through a registered output stage.

Parameters:
- N_LED, 32, number of LEDs driven (1..32). DATA bits at and above N_LED are ignored on write and read back as 0.
- PWM_BITS, 8, width of the PWM counter and the DUTY register (1..16).
- BLINK_DEFAULT, 25000000, reset value of BLINK_HALF, the half-period of blinking in clk cycles.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write strobe from the bridge.
- addr  input  2  word select (bus address bits [3:2]).
- byteen  input  4  byte enables for the write.
- wd  input  32  write data.
- rd  output  32  read data, combinational from addr.
- led_light  output  N_LED  LED pins, active-low (0 = lit).

Behaviour:
- Register map:
  - addr 0: DATA[N_LED-1:0], reset 0.
  - addr 1: CTRL, bit0 BLINK_EN, bit1 PWM_EN, all other bits read 0, reset 0.
  - addr 2: DUTY[PWM_BITS-1:0], reset all-ones.
  - addr 3: BLINK_HALF[31:0], reset BLINK_DEFAULT.
- Write rules:
  - A write commits at a posedge only when we=1 and |byteen=1.
  - Each set byteen[i] replaces byte i of the selected register. Other bytes keep their old value.
  - we=1 with byteen=0 is a no-op.
- rd returns the zero-extended selected register. It is independent of we.
- PWM:
  - pwm_cnt is PWM_BITS wide, counts every cycle and wraps from all-ones to 0. Reset value 0.
  - pwm_gate = 1 when PWM_EN=0. Otherwise pwm_gate = (DUTY == all-ones) or (pwm_cnt < DUTY).
  - DUTY=0 gives always off. DUTY=all-ones gives always on.
- Blink:
  - State: blink_cnt[31:0] and blink_phase. Reset values are 0 and 1 (on).
  - When BLINK_EN=1, blink_cnt increments each cycle. When blink_cnt reaches max(BLINK_HALF,1)-1, it returns to 0 and blink_phase toggles.
  - blink_gate = blink_phase when BLINK_EN=1, else 1.
  - A committed write to CTRL or BLINK_HALF clears blink_cnt to 0 and sets blink_phase to 1 in the same edge.
  - BLINK_HALF=0 behaves as 1, so the phase toggles every cycle.
  - When BLINK_EN=0, the counter holds at 0.
- Output:
  - led_light register = ~(DATA & {N_LED{pwm_gate & blink_gate}}). It is updated every posedge and resets to all-ones (all dark).
  - Latency: a DATA write committed at edge k appears on led_light after edge k+1.
- Reset asserted mid-operation has priority over any simultaneous write. All state returns to its reset value at that edge.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined: the PWM counter, the DUTY register and CTRL bit1 are implemented as described above.
- Undefined:
  - No PWM counter is built, and pwm_gate is constant 1.
  - DUTY reads 0 and writes to it are ignored.
  - CTRL bit1 is not stored and reads 0.
  - All other behaviour is unchanged.

Test Plan (instantiate N_LED=16, PWM_BITS=4, BLINK_DEFAULT=4, LED_PWM_EN defined):
1. Reset held 2 cycles -> led_light=16'hFFFF; reads give DATA=0, CTRL=0, DUTY=0x0000000F, BLINK_HALF=4.
2. Write DATA wd=0x1234A5C3, byteen=4'b0001 -> DATA=0x00C3; then byteen=4'b0010 with wd=0x0000A500 -> DATA=0xA5C3; led_light=16'h5A3C one edge after the commit; DATA readback 0x0000A5C3 (bits 31:16 dropped).
3. DATA=0xFFFF, CTRL=0x2, DUTY=4 -> over any 16 consecutive cycles led_light=0x0000 for exactly 4 cycles; DUTY=0 -> constantly 0xFFFF; DUTY=0xF -> constantly 0x0000.
4. DATA=0x0001, CTRL=0x1, BLINK_HALF=4 -> led_light[0] alternates 4 cycles lit, 4 cycles dark, starting lit; rewriting BLINK_HALF=2 mid-dark-phase -> lit again next output edge, then 2/2 toggling.
5. we=1, byteen=0, wd=0xFFFFFFFF to DATA -> DATA and led_light unchanged; reset asserted together with a DATA write -> DATA=0.
6. Rebuild without LED_PWM_EN; write CTRL=0x3, DUTY=5 -> CTRL reads 0x1, DUTY reads 0, brightness is unaffected and only blinking applies.

Source files
------------

// File: rtl/led_ctrl_if.sv
// CPU bridge word interface for the LED peripheral: write strobe, word select,
// byte enables, write data and combinational read data.
interface led_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, addr, byteen, wd, input rd);
  modport slave  (input we, addr, byteen, wd, output rd);
endinterface

// File: rtl/led_ctrl.sv
// Memory-mapped LED driver: DATA/CTRL/DUTY/BLINK_HALF registers, PWM brightness
// and blink timer feeding an active-low registered output. PWM is built only with LED_PWM_EN.
module led_ctrl #(
  parameter int N_LED         = 32,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_DEFAULT = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  led_ctrl_if.slave        bus,
  output logic [N_LED-1:0] led_light
);

  logic [N_LED-1:0] data_q;
  logic             blink_en;
  logic [31:0]      blink_half;
  logic [31:0]      blink_cnt;
  logic [31:0]      blink_last;
  logic             blink_phase;
  logic             blink_gate;
  logic             pwm_gate;
  logic             pwm_en_rd;
  logic [31:0]      duty_rd;
  logic             wr;
  logic             wr_data;
  logic             wr_ctrl;
  logic             wr_half;
  logic [31:0]      wr_val;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  assign wr      = bus.we && (bus.byteen != 4'b0000);
  assign wr_data = wr && (bus.addr == 2'd0);
  assign wr_ctrl = wr && (bus.addr == 2'd1);
  assign wr_half = wr && (bus.addr == 2'd3);
  // Readback already holds the addressed register zero-extended, so merging
  // against it yields the post-write value for every register.
  assign wr_val  = byte_merge(bus.rd, bus.wd, bus.byteen);

`ifdef LED_PWM_EN
  logic                pwm_en;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wr_duty;

  assign wr_duty = wr && (bus.addr == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_en  <= 1'b0;
      duty    <= '1;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wr_ctrl) pwm_en <= wr_val[1];
      if (wr_duty) duty   <= wr_val[PWM_BITS-1:0];
    end
  end

  assign pwm_gate  = !pwm_en || (duty == '1) || (pwm_cnt < duty);
  assign pwm_en_rd = pwm_en;
  assign duty_rd   = 32'(duty);
`else
  assign pwm_gate  = 1'b1;
  assign pwm_en_rd = 1'b0;
  assign duty_rd   = '0;
`endif

  // A half-period of 0 is treated as 1, i.e. terminal count 0.
  assign blink_last = (blink_half == '0) ? '0 : blink_half - 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_en    <= 1'b0;
      blink_half  <= 32'(BLINK_DEFAULT);
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (wr_ctrl) blink_en   <= wr_val[0];
      if (wr_half) blink_half <= wr_val;
      if (wr_ctrl || wr_half) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (!blink_en) begin
        blink_cnt   <= '0;
      end else if (blink_cnt == blink_last) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 32'd1;
      end
    end
  end

  assign blink_gate = !blink_en || blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      led_light <= '1;
    end else begin
      if (wr_data) data_q <= wr_val[N_LED-1:0];
      led_light <= ~(data_q & {N_LED{pwm_gate && blink_gate}});
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      2'd0:    bus.rd = 32'(data_q);
      2'd1:    bus.rd = {30'd0, pwm_en_rd, blink_en};
      2'd2:    bus.rd = duty_rd;
      default: bus.rd = blink_half;
    endcase
  end

endmodule
